data_sram_resp: RTL and testbench

Responder end of the CPU data-SRAM interface: accepts the en/wen/addr/wdata request issued from the execute stage and returns `data_sram_rdata` exactly one cycle later, where the memory stage consumes it without stalling. Backed by an internal byte-writable word array that is zero-cleared by a hardware sweep after every reset. Reports out-of-range accesses and keeps read/write access counters for the verification top.

---
 rtl/data_sram_resp_pkg.sv | 13 +
 rtl/sram_bytewrite_array.sv | 48 ++++
 rtl/data_sram_resp.sv | 119 +++++++++++
 tb/tb_data_sram_resp.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the data-SRAM responder.
package data_sram_resp_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned DEPTH_LOG2_DFLT = 10;
  localparam int unsigned CNT_W           = 16;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

endpackage : data_sram_resp_pkg

// File: rtl/sram_bytewrite_array.sv
// Single-port 32-bit word array with 4 byte enables and a registered,
// write-first read port. The read register can be loaded with zero.
module sram_bytewrite_array #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  input  logic          rd_en_i,
  input  logic          rd_zero_i,
  output logic [31:0]   rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];
  logic [31:0] merged;
  logic [31:0] rdata_q;

  // Stored word with the enabled lanes replaced by the incoming data.
  always_comb begin
    merged = mem[idx_i];
    for (int unsigned l = 0; l < 4; l++) begin
      if (we_i[l]) merged[8*l +: 8] = wdata_i[8*l +: 8];
    end
  end

  // Array update; contents are cleared by the owner's sweep, not by reset.
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 4; l++) begin
      if (we_i[l]) mem[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
    end
  end

  // Read register: holds unless a request is present.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= rd_zero_i ? '0 : merged;
    end
  end

  assign rdata_o = rdata_q;

endmodule : sram_bytewrite_array

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: clear sweep after reset, one-cycle read latency,
// out-of-range capture and saturating access counters.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DFLT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  output logic             init_done,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
  logic                  err_q, err_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

  logic                  in_range;
  logic [3:0]            arr_we;
  logic [DEPTH_LOG2-1:0] arr_idx;
  logic [31:0]           arr_wdata;
  logic                  rd_zero;

  assign in_range = (data_sram_addr[31:DEPTH_LOG2+2] == '0);

  // Next-state, sweep, request decode, error capture and counters.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    arr_we     = '0;
    arr_idx    = data_sram_addr[DEPTH_LOG2+1:2];
    arr_wdata  = data_sram_wdata;
    rd_zero    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        // Sweep owns the array port; any request just returns zero.
        arr_we    = '1;
        arr_idx   = clr_idx_q;
        arr_wdata = '0;
        rd_zero   = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = ST_READY;
      end
      ST_READY: begin
        if (data_sram_en) begin
          if (in_range) begin
            arr_we = data_sram_wen;
            if (data_sram_wen == 4'b0000) begin
              if (rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 1'b1;
            end else begin
              if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
            end
          end else begin
            rd_zero = 1'b1;
            if (!err_q) begin
              err_d      = 1'b1;
              err_addr_d = data_sram_addr;
            end
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_INIT;
      clr_idx_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  sram_bytewrite_array #(
    .AW (DEPTH_LOG2)
  ) u_array (
    .clk       (clk),
    .resetn    (resetn),
    .we_i      (arr_we),
    .idx_i     (arr_idx),
    .wdata_i   (arr_wdata),
    .rd_en_i   (data_sram_en),
    .rd_zero_i (rd_zero),
    .rdata_o   (data_sram_rdata)
  );

  assign init_done = (state_q == ST_READY);
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule : data_sram_resp

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp with DEPTH_LOG2=4 (16-word array).
module tb_data_sram_resp;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        init_done;
  logic        err;
  logic [31:0] err_addr;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int unsigned n_vec;
  int unsigned n_miss;

  data_sram_resp #(
    .DEPTH_LOG2 (4)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .init_done       (init_done),
    .err             (err),
    .err_addr        (err_addr),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    data_sram_en    = 1'b1;
    data_sram_addr  = a;
    data_sram_wen   = w;
    data_sram_wdata = d;
    tick();
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rdata"},    data_sram_rdata, 32'h0);
    chk({tag, ".init"},     {31'h0, init_done}, 32'h0);
    chk({tag, ".err"},      {31'h0, err}, 32'h0);
    chk({tag, ".err_addr"}, err_addr, 32'h0);
    chk({tag, ".rd_cnt"},   {16'h0, rd_cnt}, 32'h0);
    chk({tag, ".wr_cnt"},   {16'h0, wr_cnt}, 32'h0);
  endtask

  initial begin
    n_vec           = 0;
    n_miss          = 0;
    resetn          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;

    repeat (3) tick();
    chk_all_zero("reset");

    // Sweep: a read at edge 3 is ignored, then idle; init_done on edge 16.
    resetn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      data_sram_en   = (i == 3);
      data_sram_addr = 32'h0;
      tick();
      if (i >= 3 && i <= 6) begin
        chk("init_rdata", data_sram_rdata, 32'h0);
        chk("init_rdcnt", {16'h0, rd_cnt}, 32'h0);
        chk("init_err",   {31'h0, err}, 32'h0);
      end
      if (i == 15) chk("init_done_e15", {31'h0, init_done}, 32'h0);
      if (i == 16) chk("init_done_e16", {31'h0, init_done}, 32'h1);
    end
    data_sram_en = 1'b0;

    for (int i = 0; i < 16; i++) begin
      access(32'(i * 4), 4'b0000, 32'h0);
      chk("sweep_zero", data_sram_rdata, 32'h0);
    end
    chk("rd_cnt_16", {16'h0, rd_cnt}, 32'd16);

    // Byte-lane writes with write-first read data.
    access(32'h8, 4'hF, 32'hDEADBEEF);
    chk("wr_full", data_sram_rdata, 32'hDEADBEEF);
    access(32'h8, 4'b0101, 32'h11223344);
    chk("wr_lanes", data_sram_rdata, 32'hDE22BE44);
    access(32'h8, 4'b0000, 32'h0);
    chk("rd_merged", data_sram_rdata, 32'hDE22BE44);
    chk("wr_cnt_2", {16'h0, wr_cnt}, 32'd2);
    chk("rd_cnt_17", {16'h0, rd_cnt}, 32'd17);
    tick();
    tick();
    chk("idle_hold", data_sram_rdata, 32'hDE22BE44);
    chk("idle_rdcnt", {16'h0, rd_cnt}, 32'd17);

    access(32'hC,  4'b1010, 32'hAABBCCDD);
    chk("wr_c", data_sram_rdata, 32'hAA00CC00);
    access(32'h3C, 4'b0001, 32'h00000055);
    chk("wr_3c", data_sram_rdata, 32'h00000055);
    access(32'h0,  4'b1000, 32'h7F000000);
    chk("wr_0", data_sram_rdata, 32'h7F000000);
    access(32'hC,  4'b0000, 32'h0);
    chk("rd_c", data_sram_rdata, 32'hAA00CC00);
    access(32'h3C, 4'b0000, 32'h0);
    chk("rd_3c", data_sram_rdata, 32'h00000055);
    access(32'h0,  4'b0000, 32'h0);
    chk("rd_0", data_sram_rdata, 32'h7F000000);
    chk("wr_cnt_5", {16'h0, wr_cnt}, 32'd5);
    chk("rd_cnt_20", {16'h0, rd_cnt}, 32'd20);

    // Out-of-range accesses.
    access(32'h40, 4'b0000, 32'h0);
    chk("oor1_rdata", data_sram_rdata, 32'h0);
    chk("oor1_err", {31'h0, err}, 32'h1);
    chk("oor1_addr", err_addr, 32'h40);
    access(32'h80, 4'b0000, 32'h0);
    chk("oor2_rdata", data_sram_rdata, 32'h0);
    chk("oor2_addr", err_addr, 32'h40);
    access(32'h48, 4'hF, 32'hFFFFFFFF);
    chk("oor3_rdata", data_sram_rdata, 32'h0);
    chk("oor3_addr", err_addr, 32'h40);
    chk("oor_rdcnt", {16'h0, rd_cnt}, 32'd20);
    chk("oor_wrcnt", {16'h0, wr_cnt}, 32'd5);
    access(32'h8, 4'b0000, 32'h0);
    chk("oor_no_alias", data_sram_rdata, 32'hDE22BE44);

    // Asynchronous reset mid-operation.
    resetn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    tick();
    resetn = 1'b1;
    repeat (16) tick();
    chk("reinit_done", {31'h0, init_done}, 32'h1);
    access(32'h8, 4'b0000, 32'h0);
    chk("lost_8", data_sram_rdata, 32'h0);
    access(32'h0, 4'b0000, 32'h0);
    chk("lost_0", data_sram_rdata, 32'h0);

    // Read counter saturation: 65540 reads in total since reset.
    for (int n = 3; n <= 65540; n++) begin
      access(32'h4, 4'b0000, 32'h0);
      if (n == 65534) chk("rd_cnt_fffe", {16'h0, rd_cnt}, 32'h0000FFFE);
      if (n == 65535) chk("rd_cnt_ffff", {16'h0, rd_cnt}, 32'h0000FFFF);
    end
    chk("rd_cnt_sat", {16'h0, rd_cnt}, 32'h0000FFFF);
    chk("wr_cnt_sat", {16'h0, wr_cnt}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_data_sram_resp
